// File: rtl/paint_scheduler_if.sv
// Pixel stream from paint_scheduler toward the LCD writer: valid/ready handshake
// carrying one RGB565 pixel plus first/last frame markers.
interface paint_scheduler_if;
    logic [15:0] pix_data;
    logic        pix_first;
    logic        pix_last;
    logic        pix_valid;
    logic        pix_ready;

    modport master (output pix_data, pix_first, pix_last, pix_valid, input pix_ready);
    modport slave  (input pix_data, pix_first, pix_last, pix_valid, output pix_ready);
endinterface

// File: rtl/paint_scheduler.sv
// Raster coordinate sequencer with credit-limited issue, latency realignment and output FIFO.
// Optional frame cycle counter enabled by defining PAINT_SCHED_PERF_EN.
module paint_scheduler #(
    parameter int H_PIXELS   = 480,
    parameter int V_PIXELS   = 800,
    parameter int PIPE_LAT   = 5,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                frame_req,
    output logic                busy,
    output logic                frame_done,
    output logic signed [15:0]  paint_x,
    output logic signed [15:0]  paint_y,
    input  logic [15:0]         paint_color,
    paint_scheduler_if.master   pix,
    output logic [31:0]         frame_cycles
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int CR_W  = $clog2(FIFO_DEPTH + PIPE_LAT + 1);
    localparam logic [15:0] X_LAST = 16'(H_PIXELS - 1);
    localparam logic [15:0] Y_LAST = 16'(V_PIXELS - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_e;

    typedef struct packed {
        logic        first;
        logic        last;
        logic [15:0] color;
    } pix_t;

    state_e              state_q;
    logic [15:0]         x_q, y_q;
    logic                busy_q;

    logic [PIPE_LAT-1:0] vld_q, vld_d;
    logic [PIPE_LAT-1:0] first_q, first_d;
    logic [PIPE_LAT-1:0] last_q, last_d;

    pix_t                mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    fifo_cnt_q, fifo_cnt_d;

    logic [CR_W-1:0]     in_flight;
    logic                at_first, at_last;
    logic                issue, push, pop;
    logic                head_valid;
    pix_t                head;
    logic                frame_done_w;

    // NOTE: always_comb uses blocking assignments so each line sees the value
    // computed just above it; the accumulator is defaulted first so no latch forms.
    always_comb begin
        in_flight = '0;
        for (int i = 0; i < PIPE_LAT; i++) begin
            in_flight = in_flight + CR_W'(vld_q[i]);
        end
    end

    assign at_first = (x_q == 16'd0) && (y_q == 16'd0);
    assign at_last  = (x_q == X_LAST) && (y_q == Y_LAST);

    // Every issued coordinate reserves a FIFO slot, so a push can never find it full.
    assign issue = (state_q == S_RUN) &&
                   ((in_flight + CR_W'(fifo_cnt_q)) < CR_W'(FIFO_DEPTH));

    assign head_valid   = (fifo_cnt_q != '0);
    assign head         = mem_q[rd_ptr_q];
    assign push         = vld_q[PIPE_LAT-1];
    assign pop          = head_valid && pix.pix_ready;
    assign frame_done_w = (state_q == S_DRAIN) && pop && head.last;

    // NOTE: the controller keeps state and outputs in one clocked block; all
    // sequential assignments are non-blocking so every register updates together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (frame_req) begin
                        state_q <= S_RUN;
                        x_q     <= '0;
                        y_q     <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (issue) begin
                        // The final coordinate stays on the bus while the pipe drains.
                        if (at_last) begin
                            state_q <= S_DRAIN;
                        end else if (x_q == X_LAST) begin
                            x_q <= '0;
                            y_q <= y_q + 16'd1;
                        end else begin
                            x_q <= x_q + 16'd1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (frame_done_w) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        vld_d      = vld_q;
        first_d    = first_q;
        last_d     = last_q;
        vld_d[0]   = issue;
        first_d[0] = issue && at_first;
        last_d[0]  = issue && at_last;
        for (int i = 1; i < PIPE_LAT; i++) begin
            vld_d[i]   = vld_q[i-1];
            first_d[i] = first_q[i-1];
            last_d[i]  = last_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q   <= '0;
            first_q <= '0;
            last_q  <= '0;
        end else begin
            vld_q   <= vld_d;
            first_q <= first_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
        end
    end

    // NOTE: the storage array has no reset; an entry is only read once the
    // count says it was written, and the outputs are forced to zero while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{first: first_q[PIPE_LAT-1],
                                 last:  last_q[PIPE_LAT-1],
                                 color: paint_color};
        end
    end

`ifdef PAINT_SCHED_PERF_EN
    logic [31:0] cyc_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_cnt_q <= '0;
        end else if ((state_q == S_IDLE) && frame_req) begin
            cyc_cnt_q <= '0;
        end else if (busy_q) begin
            cyc_cnt_q <= cyc_cnt_q + 32'd1;
        end
    end

    assign frame_cycles = cyc_cnt_q;
`else
    assign frame_cycles = '0;
`endif

    assign busy          = busy_q;
    assign frame_done    = frame_done_w;
    assign paint_x       = $signed(x_q);
    assign paint_y       = $signed(y_q);
    assign pix.pix_valid = head_valid;
    assign pix.pix_data  = head_valid ? head.color : 16'd0;
    assign pix.pix_first = head_valid && head.first;
    assign pix.pix_last  = head_valid && head.last;

endmodule

// File: tb/tb_paint_scheduler.sv
// Directed bench for paint_scheduler on a 4x3 raster: a scoreboard of expected
// pixels is filled at each accepted request and drained by the pixel monitor.
module tb_paint_scheduler;

    localparam int H  = 4;
    localparam int V  = 3;
    localparam int PL = 5;
    localparam int FD = 8;

`ifdef PAINT_SCHED_PERF_EN
    localparam logic [31:0] EXP_CYC = 32'd18;
`else
    localparam logic [31:0] EXP_CYC = 32'd0;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic               frame_req;
    logic               busy;
    logic               frame_done;
    logic signed [15:0] paint_x;
    logic signed [15:0] paint_y;
    logic [15:0]        paint_color;
    logic [31:0]        frame_cycles;

    paint_scheduler_if pix_if();

    paint_scheduler #(
        .H_PIXELS  (H),
        .V_PIXELS  (V),
        .PIPE_LAT  (PL),
        .FIFO_DEPTH(FD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_req   (frame_req),
        .busy        (busy),
        .frame_done  (frame_done),
        .paint_x     (paint_x),
        .paint_y     (paint_y),
        .paint_color (paint_color),
        .pix         (pix_if),
        .frame_cycles(frame_cycles)
    );

    always #5 clk = ~clk;

    int          errors  = 0;
    int          checks  = 0;
    int          cyc     = 0;
    int          popped  = 0;
    int          done_cnt = 0;
    bit          inv_en  = 1'b0;
    logic [17:0] exp_q [$];
    logic [17:0] exp_pix;
    logic [15:0] dp_pipe [PL];

    always @(posedge clk) cyc <= cyc + 1;

    // Colour datapath model: {y,x} of the coordinate presented PL cycles earlier.
    always @(posedge clk) begin
        dp_pipe[0] <= {paint_y[7:0], paint_x[7:0]};
        for (int i = 1; i < PL; i++) dp_pipe[i] <= dp_pipe[i-1];
    end
    assign paint_color = dp_pipe[PL-1];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (pix_if.pix_valid && pix_if.pix_ready) begin
                check("pop_expected", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) begin
                    exp_pix = exp_q.pop_front();
                    check("pixel", {pix_if.pix_first, pix_if.pix_last, pix_if.pix_data}, exp_pix);
                end
                popped++;
            end
            if (frame_done) begin
                done_cnt++;
                check("done_on_last_pop",
                      pix_if.pix_valid && pix_if.pix_ready && pix_if.pix_last, 1);
            end
            if (inv_en) begin
                check("fifo_le_depth", 64'(dut.fifo_cnt_q <= FD), 64'd1);
                check("credit_le_depth", 64'(dut.in_flight + dut.fifo_cnt_q <= FD), 64'd1);
            end
        end
    end

    task automatic push_frame();
        for (int y = 0; y < V; y++) begin
            for (int x = 0; x < H; x++) begin
                exp_q.push_back({(x == 0 && y == 0), (x == H-1 && y == V-1),
                                 8'(y), 8'(x)});
            end
        end
    endtask

    task automatic to_cycle(input int t);
        while (cyc < t) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic start_frame(output int c0, output int p0, output int d0);
        @(posedge clk); #1;
        c0 = cyc;
        p0 = popped;
        d0 = done_cnt;
        frame_req = 1'b1;
        push_frame();
        @(posedge clk); #1;
        frame_req = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_busy"},       busy, 0);
        check({tag, "_frame_done"}, frame_done, 0);
        check({tag, "_paint_x"},    paint_x, 0);
        check({tag, "_paint_y"},    paint_y, 0);
        check({tag, "_pix_data"},   pix_if.pix_data, 0);
        check({tag, "_pix_first"},  pix_if.pix_first, 0);
        check({tag, "_pix_last"},   pix_if.pix_last, 0);
        check({tag, "_pix_valid"},  pix_if.pix_valid, 0);
        check({tag, "_frame_cyc"},  frame_cycles, 0);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!frame_done && n < budget) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run_frame_timed(input string tag);
        int c0, p0, d0, n;
        pix_if.pix_ready = 1'b1;
        start_frame(c0, p0, d0);
        @(negedge clk);
        check({tag, "_busy_c1"},    busy, 1);
        check({tag, "_x_c1"},       paint_x, 0);
        check({tag, "_y_c1"},       paint_y, 0);
        check({tag, "_valid_c1"},   pix_if.pix_valid, 0);
        n = 0;
        while (!pix_if.pix_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_first_valid_cycle"}, 64'(cyc - c0), 64'd7);
        check({tag, "_first_flag"}, pix_if.pix_first, 1);
        check({tag, "_first_data"}, pix_if.pix_data, 16'h0000);
        wait_done(40);
        check({tag, "_done_cycle"}, 64'(cyc - c0), 64'd18);
        @(negedge clk);
        check({tag, "_busy_after"},   busy, 0);
        check({tag, "_frame_cycles"}, frame_cycles, EXP_CYC);
        check({tag, "_pixels"},       64'(popped - p0), 64'd12);
        check({tag, "_done_count"},   64'(done_cnt - d0), 64'd1);
        check({tag, "_sb_empty"},     64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int c0, p0, d0, n;
        rst              = 1'b1;
        frame_req        = 1'b0;
        pix_if.pix_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset("por");

        // Full frame, consumer always ready: exact latency and throughput.
        run_frame_timed("basic");

        // Consumer ready about 30 % of cycles, credit invariant watched every cycle.
        start_frame(c0, p0, d0);
        inv_en = 1'b1;
        n = 0;
        while (n < 600) begin
            @(posedge clk); #1;
            pix_if.pix_ready = ($urandom_range(0, 99) < 30);
            @(negedge clk);
            n++;
            if (frame_done) break;
        end
        inv_en = 1'b0;
        pix_if.pix_ready = 1'b1;
        @(negedge clk);
        check("rand_done_count", 64'(done_cnt - d0), 64'd1);
        check("rand_pixels",     64'(popped - p0), 64'd12);
        check("rand_sb_empty",   64'(exp_q.size()), 64'd0);

        // Consumer stalled for 50 cycles: issue stops at 8 credits.
        pix_if.pix_ready = 1'b0;
        start_frame(c0, p0, d0);
        to_cycle(c0 + 20);
        @(negedge clk);
        check("stall_x_c20",   paint_x, 0);
        check("stall_y_c20",   paint_y, 2);
        check("stall_fifo_c20", dut.fifo_cnt_q, 8);
        to_cycle(c0 + 50);
        @(negedge clk);
        check("stall_x_c50",   paint_x, 0);
        check("stall_y_c50",   paint_y, 2);
        check("stall_no_pops", 64'(popped - p0), 64'd0);
        to_cycle(c0 + 51);
        pix_if.pix_ready = 1'b1;
        wait_done(60);
        @(negedge clk);
        check("stall_done_count", 64'(done_cnt - d0), 64'd1);
        check("stall_pixels",     64'(popped - p0), 64'd12);

        // Extra requests mid-frame and in the frame_done cycle are dropped.
        start_frame(c0, p0, d0);
        to_cycle(c0 + 5);
        frame_req = 1'b1;
        to_cycle(c0 + 6);
        frame_req = 1'b0;
        to_cycle(c0 + 18);
        frame_req = 1'b1;
        @(negedge clk);
        check("ignore_done_c18", frame_done, 1);
        to_cycle(c0 + 19);
        frame_req = 1'b0;
        to_cycle(c0 + 40);
        @(negedge clk);
        check("ignore_busy",       busy, 0);
        check("ignore_done_count", 64'(done_cnt - d0), 64'd1);
        check("ignore_pixels",     64'(popped - p0), 64'd12);

        // Reset in cycle 9 for two cycles, then a clean frame.
        start_frame(c0, p0, d0);
        to_cycle(c0 + 9);
        check("rst_pre_pixels", 64'(popped - p0), 64'd2);
        rst = 1'b1;
        @(negedge clk);
        check_reset("midrst");
        to_cycle(c0 + 11);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_idle_busy", busy, 0);
        run_frame_timed("after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
